// File: rtl/prbs_rx_checker_pkg.sv
// prbs_rx_checker_pkg: shared sizes, PRBS-31 constants, FSM encoding and helpers
package prbs_rx_checker_pkg;
    localparam int NUM_ELINKS = 14;
    localparam int FRAME_BITS = 112;
    localparam int CNT_BITS = 32;
    localparam int PRBS_LEN = 31;
    localparam int PRBS_TAP = 28;
    localparam logic [PRBS_LEN-1:0] PRBS_SEED = '1;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        PREAMBLE = 2'd1,
        CHECK = 2'd2
    } state_t;

    function automatic logic [FRAME_BITS+PRBS_LEN-1:0] prbs31_frame(input logic [PRBS_LEN-1:0] s);
        logic [PRBS_LEN-1:0] r;
        logic [FRAME_BITS-1:0] w;
        logic b;
        r = s;
        w = '0;
        for (int k = FRAME_BITS - 1; k >= 0; k--) begin
            b = r[PRBS_LEN-1] ^ r[PRBS_TAP-1];
            r = {r[PRBS_LEN-2:0], b};
            w[k] = b;
        end
        return {w, r};
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
        return &c ? c : c + 1'b1;
    endfunction
endpackage

// File: rtl/prbs_rx_checker_gen.sv
// prbs31_frame_gen: PRBS-31 generator producing one 112-bit word per step
module prbs31_frame_gen
    import prbs_rx_checker_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load_seed,
    input  logic                  advance,
    output logic [FRAME_BITS-1:0] word
);
    logic [PRBS_LEN-1:0] lfsr, lfsr_next;

    always_comb {word, lfsr_next} = prbs31_frame(lfsr);

    always_ff @(posedge clock) begin
        if (!reset_n || load_seed) lfsr <= PRBS_SEED;
        else if (advance) lfsr <= lfsr_next;
    end
endmodule

// File: rtl/prbs_rx_checker.sv
// prbs_rx_checker: per-e-link PRBS-31 frame checker with lock FSM and counters
module prbs_rx_checker
    import prbs_rx_checker_pkg::*;
#(
    parameter logic [FRAME_BITS-1:0] START_PATTERN = 112'h5555555555555555555555555555,
    parameter logic [NUM_ELINKS-1:0] ELINK_VALID = 14'h3FFF,
    parameter int LOSS_THRESH = 16
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [FRAME_BITS-1:0]          rx_data,
    input  logic                           rx_valid,
    input  logic                           cnt_reset,
    output logic                           locked,
    output logic [NUM_ELINKS-1:0]          link_good,
    output logic [NUM_ELINKS-1:0]          link_error,
    output logic [NUM_ELINKS*CNT_BITS-1:0] good_cnt,
    output logic [NUM_ELINKS*CNT_BITS-1:0] err_cnt,
    output logic [15:0]                    relock_cnt
);
    localparam logic [15:0] RUN_LAST = 16'(LOSS_THRESH - 1);

    logic [FRAME_BITS-1:0] mask, frame_q, gen_word;
    logic                  frame_v, is_start, check, load_seed, advance, lose;
    logic [NUM_ELINKS-1:0] eq, good_q, err_q;
    logic [15:0]           run_q, run_d;
    state_t                state_q, state_d;

    for (genvar i = 0; i < NUM_ELINKS; i++) begin : g_link
        assign mask[8*i +: 8] = {8{ELINK_VALID[i]}};
        assign eq[i] = frame_q[8*i +: 8] == gen_word[8*i +: 8];
    end

    prbs31_frame_gen u_gen (
        .clock    (clock),
        .reset_n  (reset_n),
        .load_seed(load_seed),
        .advance  (advance),
        .word     (gen_word)
    );

    always_ff @(posedge clock) begin
        frame_v <= reset_n && rx_valid;
        frame_q <= rx_data & mask;
    end

    always_comb begin
        is_start = frame_q == (START_PATTERN & mask);
        state_d = state_q;
        run_d = run_q;
        check = 1'b0;
        advance = 1'b0;
        lose = 1'b0;
        load_seed = frame_v && is_start;
        if (frame_v) begin
            case (state_q)
                HUNT: state_d = is_start ? PREAMBLE : HUNT;
                PREAMBLE: begin
                    check = !is_start;
                    advance = !is_start;
                    state_d = is_start ? PREAMBLE : CHECK;
                    run_d = '0;
                end
                default: begin
                    check = !is_start;
                    advance = !is_start;
                    lose = !is_start && (eq & ELINK_VALID) == '0 && run_q == RUN_LAST;
                    state_d = is_start ? PREAMBLE : lose ? HUNT : CHECK;
                    run_d = (is_start || lose || (eq & ELINK_VALID) != '0) ? 16'd0 : run_q + 16'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= HUNT;
            run_q <= '0;
            good_q <= '0;
            err_q <= '0;
            link_good <= '0;
            link_error <= '0;
        end else begin
            state_q <= state_d;
            run_q <= run_d;
            good_q <= check ? eq & ELINK_VALID : '0;
            err_q <= check ? ~eq & ELINK_VALID : '0;
            link_good <= good_q;
            link_error <= err_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || cnt_reset) begin
            good_cnt <= '0;
            err_cnt <= '0;
            relock_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_ELINKS; i++) begin
                if (good_q[i]) good_cnt[CNT_BITS*i +: CNT_BITS] <= sat_inc(good_cnt[CNT_BITS*i +: CNT_BITS]);
                if (err_q[i]) err_cnt[CNT_BITS*i +: CNT_BITS] <= sat_inc(err_cnt[CNT_BITS*i +: CNT_BITS]);
            end
            if (lose && !(&relock_cnt)) relock_cnt <= relock_cnt + 16'd1;
        end
    end

    assign locked = state_q == CHECK;
endmodule

// File: tb/tb_prbs_rx_checker.sv
// tb_prbs_rx_checker: table-driven and sequence checks of prbs_rx_checker
module tb_prbs_rx_checker;
    localparam logic [111:0] START = {14{8'h55}};

    typedef enum {K_IDLE, K_ZERO, K_START, K_GEN, K_FLIP, K_INV} kind_e;
    typedef struct {
        kind_e       kind;
        logic        exp_locked;
        logic [13:0] exp_good;
        logic [13:0] exp_err;
    } vec_t;

    logic clock = 1'b0, reset_n = 1'b0, rx_valid = 1'b0, cnt_reset = 1'b0;
    logic [111:0] rx_data = '0;
    logic locked, locked2;
    logic [13:0] link_good, link_error, good2, err2;
    logic [447:0] good_cnt, err_cnt, good_cnt2, err_cnt2;
    logic [15:0] relock_cnt, relock2;
    int checks = 0, errors = 0;
    bit mq[$];
    vec_t vecs[12];

    always #5 clock = ~clock;

    prbs_rx_checker dut (
        .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .cnt_reset(cnt_reset), .locked(locked), .link_good(link_good), .link_error(link_error),
        .good_cnt(good_cnt), .err_cnt(err_cnt), .relock_cnt(relock_cnt)
    );

    prbs_rx_checker #(.ELINK_VALID(14'h3FFE)) dut2 (
        .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .cnt_reset(cnt_reset), .locked(locked2), .link_good(good2), .link_error(err2),
        .good_cnt(good_cnt2), .err_cnt(err_cnt2), .relock_cnt(relock2)
    );

    task automatic chk(input string name, input logic [447:0] act, input logic [447:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input logic [447:0] v, input int i);
        return v[32*i +: 32];
    endfunction

    function automatic void model_reset();
        mq.delete();
        repeat (31) mq.push_back(1'b1);
    endfunction

    function automatic logic [111:0] model_next();
        logic [111:0] w;
        bit b;
        for (int k = 111; k >= 0; k--) begin
            b = mq[0] ^ mq[3];
            void'(mq.pop_front());
            mq.push_back(b);
            w[k] = b;
        end
        return w;
    endfunction

    function automatic logic [111:0] frame_for(input kind_e k);
        logic [111:0] w;
        w = '0;
        case (k)
            K_START: begin w = START; model_reset(); end
            K_GEN: w = model_next();
            K_FLIP: begin w = model_next(); w[40] = ~w[40]; end
            K_INV: w = ~model_next();
            default: w = '0;
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rx_valid = 1'b0;
        cnt_reset = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic starts(input int k, input bit garble);
        repeat (k) begin
            rx_data = START;
            if (garble) rx_data[7:0] = 8'($urandom);
            rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        model_reset();
    endtask

    task automatic stream(input int n, input int flip, input bit garble);
        logic [13:0] pg[3], pe[3];
        logic [13:0] g, e, ag, ae;
        int miss;
        miss = 0;
        pg = '{default: '0};
        pe = '{default: '0};
        for (int j = 0; j < n + 2; j++) begin
            rx_valid = j < n;
            if (j < n) begin
                rx_data = model_next();
                if (j == flip) rx_data[40] = ~rx_data[40];
                if (garble) rx_data[7:0] = 8'($urandom);
            end
            g = j >= n ? 14'h0 : garble ? 14'h3FFE : j == flip ? 14'h3FDF : 14'h3FFF;
            e = (j < n && j == flip) ? 14'h0020 : 14'h0;
            tick();
            pg[2] = pg[1]; pg[1] = pg[0]; pg[0] = g;
            pe[2] = pe[1]; pe[1] = pe[0]; pe[0] = e;
            ag = garble ? good2 : link_good;
            ae = garble ? err2 : link_error;
            if (ag !== pg[2] || ae !== pe[2]) miss++;
        end
        rx_valid = 1'b0;
        chk("pulse_timing", 448'(miss), 448'(0));
    endtask

    initial begin
        int quiet;
        vecs[0]  = '{K_ZERO,  1'b0, 14'h0000, 14'h0000};
        vecs[1]  = '{K_START, 1'b0, 14'h0000, 14'h0000};
        vecs[2]  = '{K_START, 1'b0, 14'h0000, 14'h0000};
        vecs[3]  = '{K_GEN,   1'b1, 14'h3FFF, 14'h0000};
        vecs[4]  = '{K_GEN,   1'b1, 14'h3FFF, 14'h0000};
        vecs[5]  = '{K_FLIP,  1'b1, 14'h3FDF, 14'h0020};
        vecs[6]  = '{K_IDLE,  1'b1, 14'h0000, 14'h0000};
        vecs[7]  = '{K_GEN,   1'b1, 14'h3FFF, 14'h0000};
        vecs[8]  = '{K_INV,   1'b1, 14'h0000, 14'h3FFF};
        vecs[9]  = '{K_GEN,   1'b1, 14'h3FFF, 14'h0000};
        vecs[10] = '{K_START, 1'b0, 14'h0000, 14'h0000};
        vecs[11] = '{K_GEN,   1'b1, 14'h3FFF, 14'h0000};

        do_reset();
        chk("rst_locked", locked, 0);
        chk("rst_good", link_good, 0);
        chk("rst_err", link_error, 0);
        chk("rst_good_cnt", good_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_relock", relock_cnt, 0);

        for (int v = 0; v < 12; v++) begin
            rx_data = frame_for(vecs[v].kind);
            rx_valid = vecs[v].kind != K_IDLE;
            tick();
            rx_valid = 1'b0;
            repeat (2) tick();
            chk($sformatf("vec%0d_locked", v), locked, vecs[v].exp_locked);
            chk($sformatf("vec%0d_good", v), link_good, vecs[v].exp_good);
            chk($sformatf("vec%0d_err", v), link_error, vecs[v].exp_err);
        end
        chk("tbl_good0", cnt(good_cnt, 0), 6);
        chk("tbl_good5", cnt(good_cnt, 5), 5);
        chk("tbl_err0", cnt(err_cnt, 0), 1);
        chk("tbl_err5", cnt(err_cnt, 5), 2);
        chk("tbl_relock", relock_cnt, 0);

        do_reset();
        starts(3, 0);
        stream(1000, -1, 0);
        chk("run_locked", locked, 1);
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("run_good%0d", i), cnt(good_cnt, i), 1000);
            chk($sformatf("run_err%0d", i), cnt(err_cnt, i), 0);
        end

        do_reset();
        starts(3, 0);
        stream(1000, 10, 0);
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("flip_good%0d", i), cnt(good_cnt, i), i == 5 ? 999 : 1000);
            chk($sformatf("flip_err%0d", i), cnt(err_cnt, i), i == 5 ? 1 : 0);
        end

        repeat (15) begin
            rx_data = ~model_next();
            rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        repeat (2) tick();
        chk("loss15_locked", locked, 1);
        rx_data = ~model_next();
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (2) tick();
        chk("loss16_locked", locked, 0);
        chk("loss16_relock", relock_cnt, 1);
        chk("loss_err3", cnt(err_cnt, 3), 16);
        chk("loss_err5", cnt(err_cnt, 5), 17);
        starts(2, 0);
        stream(20, -1, 0);
        chk("relock_locked", locked, 1);
        chk("relock_good3", cnt(good_cnt, 3), 1020);

        stream(10, -1, 0);
        quiet = 0;
        repeat (5) begin
            tick();
            if (link_good !== 14'h0 || link_error !== 14'h0) quiet++;
        end
        chk("gap_quiet", 448'(quiet), 448'(0));
        stream(10, -1, 0);
        chk("gap_good3", cnt(good_cnt, 3), 1040);
        chk("gap_err3", cnt(err_cnt, 3), 16);
        chk("gap_locked", locked, 1);

        rx_data = model_next();
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        cnt_reset = 1'b1;
        tick();
        cnt_reset = 1'b0;
        chk("clr_pulse", link_good, 14'h3FFF);
        chk("clr_good0", cnt(good_cnt, 0), 0);
        chk("clr_err3", cnt(err_cnt, 3), 0);
        chk("clr_relock", relock_cnt, 0);
        rx_data = model_next();
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (2) tick();
        chk("clr_next_good0", cnt(good_cnt, 0), 1);

        rx_data = model_next();
        rx_valid = 1'b1;
        tick();
        rx_data = model_next();
        tick();
        rx_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        chk("abort_good", link_good, 0);
        chk("abort_locked", locked, 0);
        reset_n = 1'b1;
        rx_data = model_next();
        rx_valid = 1'b1;
        quiet = 0;
        repeat (4) begin
            tick();
            rx_valid = 1'b0;
            if (link_good !== 14'h0 || link_error !== 14'h0) quiet++;
        end
        chk("abort_quiet", 448'(quiet), 448'(0));
        chk("abort_good_cnt", good_cnt, 0);
        chk("abort_hunt", locked, 0);

        do_reset();
        starts(3, 1);
        stream(200, -1, 1);
        chk("mask_locked", locked2, 1);
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("mask_good%0d", i), cnt(good_cnt2, i), i == 0 ? 0 : 200);
            chk($sformatf("mask_err%0d", i), cnt(err_cnt2, i), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
